// File: rtl/ifc_accum_bank.sv
// ifc_accum_bank
//   A bank of NCH channels, each holding an NX-bit accumulator (x) and an
//   NX-bit saturating down-counter (y). Beats arrive on a valid/ready input
//   handshake and are either channel loads or computes. A compute produces a
//   single registered result on a valid/ready output handshake, one cycle
//   after acceptance, and updates that channel's x and y.
//
// Ports
//   clock     : single clock, all state changes on its rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : input beat present
//   in_ready  : block can accept a beat this cycle
//   in_ch     : channel select for the beat
//   load      : beat is a channel load (1) or a compute (0)
//   a, b, q   : compute operands, NA bits
//   x_init    : accumulator load value, NX bits
//   y_init    : down-counter load value, NX bits
//   out_valid : a result is held
//   out_ready : consumer takes the held result
//   out_ch    : channel that produced the held result
//   out_z     : held result, NX bits
//   y_zero    : bit i set while channel i's down-counter is zero

module ifc_accum_bank #(
    parameter int NX    = 16,
    parameter int NA    = 8,
    parameter int NCH   = 4,
    parameter int X_RST = 17,
    parameter int Y_RST = 21,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic          load,
    input  logic [NA-1:0] a,
    input  logic [NA-1:0] b,
    input  logic [NA-1:0] q,
    input  logic [NX-1:0] x_init,
    input  logic [NX-1:0] y_init,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [NX-1:0] out_z,
    output logic [NCH-1:0] y_zero
);

    logic [NX-1:0] x_reg [NCH];
    logic [NX-1:0] y_reg [NCH];

    logic          accept;
    logic          ch_ok;
    logic [NX-1:0] x_sel;
    logic [NX-1:0] y_sel;
    logic [NX-1:0] z_next;

    // The output slot is free when empty or being drained this cycle, so a
    // take and a new compute can share a cycle for full throughput.
    assign in_ready = (!out_valid || out_ready) && !reset;
    assign accept   = in_valid && in_ready;

    // in_ch is one bit wider in the compare so NCH itself is representable
    // when NCH is a power of two.
    assign ch_ok = ({1'b0, in_ch} < (CW+1)'(NCH));

    // Read mux over the channel registers; an out-of-range channel selects
    // nothing, and that beat is discarded anyway.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ch == CW'(i)) begin
                x_sel = x_reg[i];
                y_sel = y_reg[i];
            end
        end
    end

    // (a&b)|(a^b) reduces to a|b; it is written out so the intent is
    // traceable. Subtraction wraps modulo 2^NX.
    assign z_next = NX'((a & b) | (a ^ b)) | (x_sel + y_sel - NX'(q));

    // Output register: a new compute overrides a pending take, otherwise a
    // take empties the slot. Loads and discarded beats leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_ch    <= '0;
        end else if (accept && !load && ch_ok) begin
            out_valid <= 1'b1;
            out_z     <= z_next;
            out_ch    <= in_ch;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-channel state: loads overwrite both registers; computes add a to
    // the accumulator (wrapping) and decrement the counter, stopping at 0.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                x_reg[i] <= NX'(X_RST);
                y_reg[i] <= NX'(Y_RST);
            end else if (accept && ch_ok && (in_ch == CW'(i))) begin
                if (load) begin
                    x_reg[i] <= x_init;
                    y_reg[i] <= y_init;
                end else begin
                    x_reg[i] <= x_reg[i] + NX'(a);
                    y_reg[i] <= (y_reg[i] == '0) ? '0 : y_reg[i] - 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_yzero
            assign y_zero[g] = (y_reg[g] == '0);
        end
    endgenerate

endmodule

// File: tb/tb_ifc_accum_bank.sv
// tb_ifc_accum_bank
//   Directed bench for ifc_accum_bank at default parameters. A vector table
//   walks reset, computes, loads, saturation and back-to-back beats; short
//   hand-written sequences cover output back-pressure and reset during a
//   held result. Channel registers are inspected by hierarchical reference.

module tb_ifc_accum_bank;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic        load;
    logic [7:0]  a, b, q;
    logic [15:0] x_init, y_init;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [15:0] out_z;
    logic [3:0]  y_zero;

    int checks = 0;
    int errors = 0;

    ifc_accum_bank dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .load      (load),
        .a         (a),
        .b         (b),
        .q         (q),
        .x_init    (x_init),
        .y_init    (y_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_z     (out_z),
        .y_zero    (y_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        ld;
        logic [1:0]  ch;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [15:0] xi;
        logic [15:0] yi;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic        chk_z;
        logic [15:0] exp_z;
        logic [1:0]  exp_ch;
        logic [3:0]  exp_yz;
    } vec_t;

    vec_t vecs [10];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one beat at the falling edge; in_ready is checked before the
    // rising edge since it is combinational.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        reset     = v.rst;
        in_valid  = v.vld;
        load      = v.ld;
        in_ch     = v.ch;
        a         = v.a;
        b         = v.b;
        q         = v.q;
        x_init    = v.xi;
        y_init    = v.yi;
        out_ready = v.ordy;
        #1;
        check_val("in_ready", {31'b0, in_ready}, {31'b0, v.exp_rdy});
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input vec_t v);
        check_val("out_valid", {31'b0, out_valid}, {31'b0, v.exp_ov});
        if (v.chk_z) begin
            check_val("out_z", {16'b0, out_z}, {16'b0, v.exp_z});
            check_val("out_ch", {30'b0, out_ch}, {30'b0, v.exp_ch});
        end
        check_val("y_zero", {28'b0, y_zero}, {28'b0, v.exp_yz});
    endtask

    task automatic check_state(input int ch, input logic [15:0] ex, input logic [15:0] ey);
        logic [15:0] xv;
        logic [15:0] yv;
        case (ch)
            0: begin xv = dut.x_reg[0]; yv = dut.y_reg[0]; end
            1: begin xv = dut.x_reg[1]; yv = dut.y_reg[1]; end
            2: begin xv = dut.x_reg[2]; yv = dut.y_reg[2]; end
            default: begin xv = dut.x_reg[3]; yv = dut.y_reg[3]; end
        endcase
        check_val($sformatf("x[%0d]", ch), {16'b0, xv}, {16'b0, ex});
        check_val($sformatf("y[%0d]", ch), {16'b0, yv}, {16'b0, ey});
    endtask

    vec_t hv;

    initial begin
        reset = 1'b1; in_valid = 1'b0; load = 1'b0; in_ch = '0;
        a = '0; b = '0; q = '0; x_init = '0; y_init = '0; out_ready = 1'b0;

        //          rst  vld  ld   ch  a      b      q      xi       yi       ordy rdy  ov   chkz z         ch  yz
        vecs[0] = '{1'b1,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0000,2'd0,4'b0000};
        // 3|5=7, 17+21-2=36=0x24 -> 0x27
        vecs[1] = '{1'b0,1'b1,1'b0,2'd0,8'h03,8'h05,8'h02,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0027,2'd0,4'b0000};
        vecs[2] = '{1'b0,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0,4'b0000};
        vecs[3] = '{1'b0,1'b1,1'b1,2'd2,8'h00,8'h00,8'h00,16'hFFFF,16'h0001,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0,4'b0000};
        // FFFF+1 wraps to 0 -> 0x0002; X2=1, Y2=0
        vecs[4] = '{1'b0,1'b1,1'b0,2'd2,8'h02,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0002,2'd2,4'b0100};
        // X2+Y2=1; Y2 stays 0
        vecs[5] = '{1'b0,1'b1,1'b0,2'd2,8'h00,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0001,2'd2,4'b0100};
        // ch1 back-to-back: 38|1=0x27, then 18+20=38|1=0x27
        vecs[6] = '{1'b0,1'b1,1'b0,2'd1,8'h01,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0027,2'd1,4'b0100};
        vecs[7] = '{1'b0,1'b1,1'b0,2'd1,8'h01,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0027,2'd1,4'b0100};
        // ch3: 0x80|0x01=0x81, 38-255 mod 2^16=0xFF27 -> 0xFFA7
        vecs[8] = '{1'b0,1'b1,1'b0,2'd3,8'h80,8'h01,8'hFF,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'hFFA7,2'd3,4'b0100};
        vecs[9] = '{1'b0,1'b0,1'b0,2'd0,8'h00,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b0,1'b0,16'h0000,2'd0,4'b0100};

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i]);
            if (i == 1) check_state(0, 16'd20, 16'd20);
            if (i == 4) check_state(2, 16'h0001, 16'h0000);
        end

        check_state(0, 16'd20, 16'd20);
        check_state(1, 16'd19, 16'd19);
        check_state(2, 16'd1, 16'd0);
        check_state(3, 16'd145, 16'd20);

        // Back-pressure: first beat accepted (20+20=40=0x28), X0=20, Y0=19.
        hv = '{1'b0,1'b1,1'b0,2'd0,8'h00,8'h00,8'h00,16'h0000,16'h0000,1'b0,1'b1,1'b1,1'b1,16'h0028,2'd0,4'b0100};
        apply_stimulus(hv);
        check_output(hv);
        // Second beat offered twice while stalled: not accepted, result held.
        for (int k = 0; k < 2; k++) begin
            hv = '{1'b0,1'b1,1'b0,2'd1,8'h10,8'h00,8'h00,16'h0000,16'h0000,1'b0,1'b0,1'b1,1'b1,16'h0028,2'd0,4'b0100};
            apply_stimulus(hv);
            check_output(hv);
        end
        check_state(1, 16'd19, 16'd19);
        // Release: second beat accepted on ch1: 0x10 | (19+19=38=0x26) = 0x36.
        hv = '{1'b0,1'b1,1'b0,2'd1,8'h10,8'h00,8'h00,16'h0000,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0036,2'd1,4'b0100};
        apply_stimulus(hv);
        check_output(hv);
        check_state(0, 16'd20, 16'd19);
        check_state(1, 16'd35, 16'd18);

        // Reset while a result is held and a beat is offered: all dropped.
        hv = '{1'b1,1'b1,1'b1,2'd3,8'h55,8'h00,8'h00,16'h1234,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0000,2'd0,4'b0000};
        apply_stimulus(hv);
        check_output(hv);
        for (int c = 0; c < 4; c++) check_state(c, 16'd17, 16'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/ifc_accum_bank.md
IFC_ACCUM_BANK -- requirements
Module: ifc_accum_bank

Interface
REQ-001 The block SHALL have parameter NX, default 16, giving the accumulator, down-counter and result width.
REQ-002 The block SHALL have parameter NA, default 8, giving the operand width; NA <= NX.
REQ-003 The block SHALL have parameter NCH, default 4, giving the channel count; NCH >= 1.
REQ-004 The block SHALL have parameter X_RST, default 17, giving the accumulator reset value.
REQ-005 The block SHALL have parameter Y_RST, default 21, giving the down-counter reset value.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase names them.
REQ-007 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port RST, input, 1 bit: synchronous, active-high reset.
REQ-009 Port IN_VALID, input, 1 bit: the input beat is present.
REQ-010 Port IN_READY, output, 1 bit: the block can accept a beat.
REQ-011 Port IN_CH, input, max(1,clog2(NCH)) bits: channel select.
REQ-012 Port LOAD, input, 1 bit: the beat is a channel load, not a compute.
REQ-013 Ports A, B and Q, input, NA bits each: operands.
REQ-014 Ports X_INIT and Y_INIT, input, NX bits each: load values.
REQ-015 Port OUT_VALID, output, 1 bit: a result is held.
REQ-016 Port OUT_READY, input, 1 bit: the consumer takes the result.
REQ-017 Port OUT_CH, output, max(1,clog2(NCH)) bits: channel of the held result.
REQ-018 Port OUT_Z, output, NX bits: the result.
REQ-019 Port Y_ZERO, output, NCH bits: bit i is set when channel i's down-counter equals 0.

Function
REQ-020 Each channel SHALL hold an NX-bit accumulator X[i] and an NX-bit down-counter Y[i].
REQ-021 A beat SHALL be accepted on a rising edge with IN_VALID=1, IN_READY=1 and RST=0.
REQ-022 IN_READY SHALL equal (!OUT_VALID | OUT_READY) & !RST, combinationally.
REQ-023 An accepted compute beat (LOAD=0) SHALL register OUT_Z = zext((A&B)|(A^B)) | ((X[ch]+Y[ch]-zext(Q)) mod 2^NX), using the pre-update X and Y.
REQ-024 An accepted compute beat SHALL also set OUT_CH=IN_CH and OUT_VALID=1; latency is 1 cycle.
REQ-025 An accepted compute beat SHALL update X[ch] <= (X[ch]+zext(A)) mod 2^NX (wrap-around).
REQ-026 An accepted compute beat SHALL update Y[ch] <= Y[ch]-1, saturating at 0 (no wrap).
REQ-027 An accepted load beat (LOAD=1) SHALL set X[ch]=X_INIT and Y[ch]=Y_INIT, produce no output, and leave OUT_* unchanged.
REQ-028 While OUT_VALID=1 and OUT_READY=0, OUT_Z and OUT_CH SHALL hold stable and no beat is accepted.
REQ-029 OUT_VALID=1 with OUT_READY=1 and no new compute beat SHALL clear OUT_VALID next cycle.
REQ-030 A simultaneous output take and new compute beat SHALL replace the output, giving sustained throughput of 1 beat per cycle.
REQ-031 Back-to-back compute beats on one channel SHALL see the previous beat's updated X and Y (no stale read).
REQ-032 An accepted beat with IN_CH >= NCH SHALL be consumed and discarded, with no state change and no output.
REQ-033 Y_ZERO SHALL be derived combinationally from the Y registers.

Reset
REQ-034 While RST=1 at a rising edge, every X[i] SHALL be set to X_RST and every Y[i] to Y_RST.
REQ-035 While RST=1 at a rising edge, OUT_VALID SHALL be set to 0, OUT_Z to 0 and OUT_CH to 0.
REQ-036 RST SHALL override any concurrent beat or pending output; a result held mid-handshake is dropped.
REQ-037 While RST=1, IN_READY SHALL be 0.

Verification (defaults NX=16, NA=8, NCH=4)
REQ-038 After reset, compute ch0 with A=0x03, B=0x05, Q=0x02 -> next cycle OUT_Z=0x0027, OUT_CH=0; then X0=20, Y0=20.
REQ-039 OUT_READY=0, two beats offered -> first is accepted; IN_READY=0 afterward; OUT_Z is held; the second is accepted the cycle after OUT_READY=1.
REQ-040 Load ch2 with X=0xFFFF, Y=0x0001, then compute A=0x02, B=0, Q=0 -> OUT_Z=0x0002, X2=0x0001, Y2=0, Y_ZERO[2]=1.
REQ-041 Continuing REQ-040, a further compute on ch2 -> Y2 stays 0.
REQ-042 Two consecutive compute beats on ch1 with A=0x01, B=0, Q=0 and OUT_READY=1 -> OUT_Z=0x0027 on both beats, one beat per cycle; then X1=19, Y1=19.
REQ-043 RST=1 while OUT_VALID=1 and OUT_READY=0 -> next cycle OUT_VALID=0 and all X=17, Y=21; Y_ZERO=0000.
